// File: rtl/im_sync.sv
// im_sync: synchronous-read instruction memory with a program-load port, stall/flush and fault flags.
module im_sync #(
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 128,
    parameter int              AW       = 7,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [AW+1:0]     fetch_addr,
    input  logic              fetch_stall,
    input  logic              fetch_flush,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_fault,
    input  logic              prog_en,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_err
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic              valid_q, valid_d, fault_q, fault_d, err_q, err_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [AW-1:0]     idx;
    logic              bad, prog_ok;
    assign idx     = fetch_addr[AW+1:2];
    assign bad     = (|fetch_addr[1:0]) || ({1'b0, idx} >= DEPTH_W);
    assign prog_ok = {1'b0, prog_addr} < DEPTH_W;
    always_comb begin
        valid_d = valid_q;
        fault_d = fault_q;
        data_d  = data_q;
        err_d   = err_q;
        if (prog_en) begin
            valid_d = 1'b0;
            fault_d = 1'b0;
            err_d   = err_q | (prog_we & ~prog_ok);
        end else if (fetch_flush) begin
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (!fetch_stall) begin
            valid_d = fetch_req;
            fault_d = fetch_req & bad;
            data_d  = !fetch_req ? data_q : bad ? NOP_WORD : mem[idx];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            fault_q <= fault_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
    // no reset on the array so it can map onto a RAM macro
    always_ff @(posedge clk) begin
        if (!rst && prog_en && prog_we && prog_ok)
            mem[prog_addr] <= prog_data;
    end
    assign fetch_valid = valid_q;
    assign fetch_fault = fault_q;
    assign fetch_data  = data_q;
    assign prog_err    = err_q;
endmodule

// File: tb/tb_im_sync.sv
// tb_im_sync: directed plus random checks of im_sync (DEPTH=100) against a behavioural memory model.
module tb_im_sync;
    localparam int DEPTH = 100;
    logic        clk = 1'b0;
    logic        rst, fetch_req, fetch_stall, fetch_flush, prog_en, prog_we;
    logic [8:0]  fetch_addr;
    logic [6:0]  prog_addr;
    logic [31:0] prog_data;
    logic        fetch_valid, fetch_fault, prog_err;
    logic [31:0] fetch_data;
    logic [31:0] mm [128];
    logic        e_valid = 1'b0, e_fault = 1'b0, e_err = 1'b0;
    logic [31:0] e_data = '0;
    logic [31:0] saved;
    int          vectors = 0, miscompares = 0;

    im_sync #(.DATA_W(32), .DEPTH(DEPTH), .AW(7), .NOP_WORD(32'h0)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_stall(fetch_stall), .fetch_flush(fetch_flush), .fetch_valid(fetch_valid),
        .fetch_data(fetch_data), .fetch_fault(fetch_fault), .prog_en(prog_en),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_err(prog_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic pe, input logic pw, input int pa,
                        input logic [31:0] pd, input logic fr, input int fa,
                        input logic st, input logic fl);
        int w;
        logic b;
        @(negedge clk);
        rst = r; prog_en = pe; prog_we = pw; prog_addr = 7'(pa); prog_data = pd;
        fetch_req = fr; fetch_addr = 9'(fa); fetch_stall = st; fetch_flush = fl;
        w = (fa % 512) / 4;
        b = (fa % 4 != 0) || (w >= DEPTH);
        if (r) begin
            e_valid = 0; e_fault = 0; e_data = 0; e_err = 0;
        end else if (pe) begin
            e_valid = 0; e_fault = 0;
            if (pw && pa < DEPTH) mm[pa] = pd;
            else if (pw) e_err = 1;
        end else if (fl) begin
            e_valid = 0; e_fault = 0;
        end else if (!st) begin
            e_valid = fr;
            e_fault = fr && b;
            if (fr) e_data = b ? 32'h0 : mm[w];
        end
        @(posedge clk);
        #1;
        chk("fetch_valid", 32'(fetch_valid), 32'(e_valid));
        chk("fetch_fault", 32'(fetch_fault), 32'(e_fault));
        chk("fetch_data", fetch_data, e_data);
        chk("prog_err", 32'(prog_err), 32'(e_err));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mm[i] = '0;
        rst = 1; prog_en = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
        fetch_req = 0; fetch_addr = 0; fetch_stall = 0; fetch_flush = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_valid", 32'(fetch_valid), 0);
        chk("reset_data", fetch_data, 0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, i, $urandom, 0, 0, 0, 0);
        step(0, 1, 1, 0, 32'h8C10_0000, 0, 0, 0, 0);
        step(0, 1, 1, 2, 32'h0211_9020, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 'h000, 0, 0);
        chk("load_fetch0", fetch_data, 32'h8C10_0000);
        chk("load_valid0", 32'(fetch_valid), 1);
        step(0, 0, 0, 0, 0, 1, 'h008, 0, 0);
        chk("load_fetch8", fetch_data, 32'h0211_9020);
        chk("load_fault8", 32'(fetch_fault), 0);
        step(0, 0, 0, 0, 0, 1, 'h006, 0, 0);
        chk("misalign_fault", 32'(fetch_fault), 1);
        chk("misalign_data", fetch_data, 0);
        step(0, 0, 0, 0, 0, 1, 'h190, 0, 0);
        chk("range_fault", 32'(fetch_fault), 1);
        chk("range_valid", 32'(fetch_valid), 1);
        step(0, 0, 0, 0, 0, 1, 'h18C, 0, 0);
        chk("last_word_ok", 32'(fetch_fault), 0);
        step(0, 1, 1, 100, 32'h1234_5678, 0, 0, 0, 0);
        chk("prog_err_set", 32'(prog_err), 1);
        step(0, 0, 0, 0, 0, 1, 'h000, 0, 0);
        chk("prog_err_sticky", 32'(prog_err), 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1, 'h008, 1, 0);
            chk("stall_data", fetch_data, 32'h8C10_0000);
            chk("stall_valid", 32'(fetch_valid), 1);
        end
        step(0, 0, 0, 0, 0, 1, 'h008, 0, 0);
        chk("after_stall", fetch_data, 32'h0211_9020);
        step(0, 0, 0, 0, 0, 1, 'h004, 1, 1);
        chk("flush_valid", 32'(fetch_valid), 0);
        chk("flush_data_hold", fetch_data, 32'h0211_9020);
        step(0, 1, 1, 0, 32'h0800_000D, 1, 'h000, 0, 0);
        chk("load_blocks", 32'(fetch_valid), 0);
        step(0, 0, 0, 0, 0, 1, 'h000, 0, 0);
        chk("reload_fetch", fetch_data, 32'h0800_000D);
        step(0, 0, 0, 0, 0, 1, 'h006, 0, 0);
        chk("pre_rst_fault", 32'(fetch_fault), 1);
        saved = mm[1];
        step(1, 1, 1, 1, ~saved, 1, 'h004, 0, 0);
        chk("rst_valid", 32'(fetch_valid), 0);
        chk("rst_err", 32'(prog_err), 0);
        step(0, 0, 0, 0, 0, 1, 'h004, 0, 0);
        chk("rst_write_lost", fetch_data, saved);
        step(0, 0, 0, 0, 0, 1, 'h000, 0, 0);
        chk("mem0_kept", fetch_data, 32'h0800_000D);
        for (int n = 0; n < 600; n++) begin
            int r, fa;
            r  = $urandom_range(0, 99);
            fa = ($urandom_range(0, 1) == 1) ? 4 * $urandom_range(0, DEPTH - 1)
                                              : $urandom_range(0, 511);
            step(r < 2, r >= 2 && r < 14, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 127) : $urandom_range(0, DEPTH - 1),
                 $urandom, $urandom_range(0, 4) != 0, fa,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/im_sync.md
Name: im_sync

Overview:
- Parametrised, synchronous-read instruction memory for the MIPS core; successor to the fixed 128x32 combinational instruction ROM.
- Takes byte addresses from the fetch stage and returns instruction words with one cycle of latency.
- Supports pipeline stall and flush on the fetch path.
- Provides a program-load port so the image is written at run time rather than hard-coded.
- Flags misaligned and out-of-range fetches.

Parameters:
- DATA_W, 32: instruction word width in bits.
- DEPTH, 128: number of words implemented; must satisfy 1 <= DEPTH <= 2^AW.
- AW, 7: word-index width; byte address width is AW+2.
- NOP_WORD, 32'h0000_0000: word returned on a faulting fetch (sll $0,$0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request for fetch_addr this cycle.
- fetch_addr  in  AW+2  byte address of the instruction (PC).
- fetch_stall  in  1  hold the fetch output registers.
- fetch_flush  in  1  discard the word in flight.
- fetch_valid  out  1  fetch_data/fetch_fault are meaningful.
- fetch_data  out  DATA_W  instruction word (registered).
- fetch_fault  out  1  the returned fetch was misaligned or out of range.
- prog_en  in  1  load mode; the fetch path is blocked.
- prog_we  in  1  write strobe, honoured only when prog_en=1.
- prog_addr  in  AW  word index to write.
- prog_data  in  DATA_W  word to write.
- prog_err  out  1  sticky flag: a write targeted an index >= DEPTH.

Behaviour:
- Clock and reset:
  - One clock, clk; reset rst is synchronous and active-high.
  - On a rising edge with rst=1: fetch_valid=0, fetch_data=0, fetch_fault=0, prog_err=0.
  - Memory writes are suppressed during rst.
  - Memory contents are not cleared by rst; they are zero at simulation start.
- Priority per edge: rst > prog_en > fetch_flush > fetch_stall > fetch_req.
- Word index is fetch_addr[AW+1:2].
- Fault condition is fetch_addr[1:0] != 0 OR index >= DEPTH.
- Normal fetch (fetch_req=1, no stall, flush or prog_en at edge N):
  - At N+1: fetch_valid=1.
  - Without a fault: fetch_data=mem[index], fetch_fault=0.
  - With a fault: fetch_data=NOP_WORD, fetch_fault=1; no memory access side effects.
- fetch_req=0 (no stall): next cycle fetch_valid=0, fetch_fault=0; fetch_data holds its last value.
- Stall (fetch_stall=1, no flush or prog_en):
  - fetch_valid, fetch_data and fetch_fault hold unchanged.
  - The concurrent fetch_req is dropped; the core re-presents it after the stall.
- Flush (fetch_flush=1, no prog_en):
  - Next cycle fetch_valid=0, fetch_fault=0, regardless of fetch_stall and fetch_req.
  - fetch_data holds its last value.
- Load mode (prog_en=1):
  - Next cycle fetch_valid=0, fetch_fault=0; fetch requests are ignored.
  - With prog_we=1 and prog_addr < DEPTH: mem[prog_addr] <= prog_data at the edge.
  - With prog_we=1 and prog_addr >= DEPTH: the write is discarded and prog_err <= 1.
  - prog_err stays set until rst.
- Leaving load mode: a fetch_req in the first cycle with prog_en=0 returns the newly written data at the following edge. There is no read/write collision, because fetch is blocked during load.
- Reset mid-load: any write on the reset edge is lost; words written on earlier edges are kept.
- The address decode must not wrap. When DEPTH < 2^AW, indices DEPTH..2^AW-1 fault instead of aliasing.

Test Plan:
- Load then fetch:
  - Stimulus: rst 1 cycle; prog_en=1, write mem[0]=32'h8C10_0000 and mem[2]=32'h0211_9020; prog_en=0; fetch_req with fetch_addr=0x000, then 0x008.
  - Required: fetch_data=32'h8C10_0000 with valid on the next cycle, then 32'h0211_9020; fault=0.
- Misalign and range, with DEPTH=100:
  - Stimulus: fetch_addr=0x006.
  - Required: valid=1, fault=1, data=0.
  - Stimulus: fetch_addr=0x190 (index 100).
  - Required: valid=1, fault=1, data=0.
  - Stimulus: prog write with prog_addr=100.
  - Required: prog_err=1, and it stays 1 until rst.
- Stall hold:
  - Stimulus: fetch 0x000 and receive the word; assert fetch_stall for 3 cycles while presenting fetch_addr=0x008.
  - Required: data stays 32'h8C10_0000 and valid=1 throughout; after the stall releases, the re-presented 0x008 returns 32'h0211_9020 one cycle later.
- Flush over stall:
  - Stimulus: fetch_flush=1 and fetch_stall=1 on the same edge.
  - Required: next cycle valid=0, fault=0.
- Load blocks fetch:
  - Stimulus: fetch_req=1 with prog_en=1 and prog_we=1 writing mem[0]=32'h0800_000D.
  - Required: valid=0 during load.
  - Stimulus: first fetch of 0x000 after prog_en drops.
  - Required: returns 32'h0800_000D.
- Reset mid-operation:
  - Stimulus: assert rst while valid=1 and fault=1, with prog_en=1 and prog_we=1 writing mem[1].
  - Required: next cycle all outputs 0; mem[1] unchanged; mem[0] keeps 32'h0800_000D.
